alu_regfile_pipe: RTL and testbench
===================================

ALU_REGFILE_PIPE -- requirements
Module: alu_regfile_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand/result/register width in bits (>=2).
REQ-002 Parameter ADDR_W, default 4, register-file address width; depth = 2**ADDR_W entries.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  DATA_W  external write data.
REQ-006 write_enable  input  1  external write request.
REQ-007 addr_write  input  ADDR_W  external write address.
REQ-008 write_ack  output  1  combinational; high when the external write commits this cycle.
REQ-009 op_valid  input  1  operation request.
REQ-010 op_ready  output  1  tied high outside reset; low while reset is high.
REQ-011 addr0, addr1  input  ADDR_W each  source operand addresses (in0, in1).
REQ-012 addr_dst  input  ADDR_W  writeback destination.
REQ-013 wb_enable  input  1  write the result back to addr_dst.
REQ-014 select  input  3  ALU operation code.
REQ-015 result  output  DATA_W  registered ALU result.
REQ-016 zero_flag, carry_flag  output  1 each  registered flags of result.
REQ-017 result_valid  output  1  one-cycle pulse per completed operation.

Function
REQ-018 Operation accepted on the rising edge where op_valid && op_ready; no other handshake condition.
REQ-019 Two stages: accept edge latches operands, select, addr_dst, wb_enable into stage E; next edge registers ALU output into result/flags, pulses result_valid, and performs writeback.
REQ-020 Latency: op accepted at edge k -> result, flags, result_valid=1 visible in the cycle after edge k+1; throughput one op per cycle.
REQ-021 Operand source priority at acceptance: (1) stage-E ALU output if E valid, E wb_enable=1 and E addr_dst equals the source address; (2) data if write_ack=1 and addr_write equals the source address; (3) register-file contents.
REQ-022 select codes: 000 ADD, 001 SUB (in0-in1), 010 AND, 011 OR, 100 XOR, 101 SHL in0 by 1, 110 SHR in0 by 1 (logical), 111 PASS in0.
REQ-023 carry_flag: ADD carry-out of bit DATA_W-1; SUB 1 iff in0<in1 unsigned (borrow); SHL in0[DATA_W-1]; SHR in0[0]; 0 for all other codes.
REQ-024 Arithmetic modulo 2**DATA_W; zero_flag = (result == 0).
REQ-025 result, zero_flag, carry_flag hold their last values between operations; result_valid low in cycles without a completing op.
REQ-026 Register file has one write port; writeback and external write compete for it.
REQ-027 Writeback has priority: write_ack = write_enable && !(E valid && E wb_enable); a denied external write is dropped and must be retried by the source.
REQ-028 wb_enable=0: result and flags update, register file unchanged, no forwarding from that op.
REQ-029 addr_dst equal to addr0 or addr1 is legal; sources use pre-writeback values.
REQ-030 Back-to-back dependent ops need no stall; forwarding per REQ-021 supplies the correct value.

Reset
REQ-031 While reset high: all register-file entries cleared to 0, stage E invalidated, result=0, zero_flag=0, carry_flag=0, result_valid=0, op_ready=0, write_ack=0.
REQ-032 Reset asserted with an op in stage E: op discarded, no writeback, no result_valid pulse.
REQ-033 Operations and writes accepted from the first edge after reset deasserts.

Verification
REQ-034 Reset, write R1=0x7F, R2=0x01, op ADD R1,R2->R3 -> two cycles later result=0x80, zero=0, carry=0; R3 reads 0x80.
REQ-035 R1=0xFF, R2=0x01, ADD -> result=0x00, zero=1, carry=1; SUB R2-R1 -> result=0x02, carry=1.
REQ-036 Back-to-back: op A ADD R1,R2->R4 then op B ADD R4,R4->R5 next cycle with R1=3,R2=4 -> B result=14 (forwarded), R5=14.
REQ-037 External write to R6 in same cycle as writeback of op A to R4 -> write_ack=0, R6 unchanged; retry next cycle -> write_ack=1, R6 updated.
REQ-038 SHL of 0x81 -> result=0x02, carry=1; SHR of 0x81 -> result=0x40, carry=1; PASS of 0x00 -> zero=1, carry=0.
REQ-039 Accept op with wb_enable=1 then assert reset next cycle -> no result_valid pulse, destination register reads 0 after reset.

Source files
------------

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: two-stage ALU over a forwarding register file with a shared write port
module alu_regfile_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_write_enable,
  input  logic [ADDR_W-1:0] i_addr_write,
  output logic              o_write_ack,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr_dst,
  input  logic              i_wb_enable,
  input  logic [2:0]        i_select,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero_flag,
  output logic              o_carry_flag,
  output logic              o_result_valid
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] r_rf [DEPTH];
  logic              r_e_valid;
  logic [DATA_W-1:0] r_e_a;
  logic [DATA_W-1:0] r_e_b;
  logic [2:0]        r_e_sel;
  logic [ADDR_W-1:0] r_e_dst;
  logic              r_e_wb;
  logic              w_wb;
  logic              w_accept;
  logic [DATA_W:0]   w_alu;
  logic [DATA_W-1:0] w_src0;
  logic [DATA_W-1:0] w_src1;
  assign w_wb        = r_e_valid && r_e_wb;
  assign o_op_ready  = !i_reset;
  assign o_write_ack = !i_reset && i_write_enable && !w_wb;
  assign w_accept    = i_op_valid && o_op_ready;
  // ALU on stage E operands; bit DATA_W carries the carry/borrow/shifted-out bit
  always_comb begin
    w_alu = r_e_sel == 3'b000 ? {1'b0, r_e_a} + {1'b0, r_e_b} :
            r_e_sel == 3'b001 ? {1'b0, r_e_a} - {1'b0, r_e_b} :
            r_e_sel == 3'b010 ? {1'b0, r_e_a & r_e_b} :
            r_e_sel == 3'b011 ? {1'b0, r_e_a | r_e_b} :
            r_e_sel == 3'b100 ? {1'b0, r_e_a ^ r_e_b} :
            r_e_sel == 3'b101 ? {r_e_a, 1'b0} :
            r_e_sel == 3'b110 ? {r_e_a[0], 1'b0, r_e_a[DATA_W-1:1]} :
                                {1'b0, r_e_a};
  end
  // operand fetch: in-flight writeback first, then same-cycle external write, then storage
  always_comb begin
    w_src0 = w_wb && r_e_dst == i_addr0 ? w_alu[DATA_W-1:0] :
             o_write_ack && i_addr_write == i_addr0 ? i_data : r_rf[i_addr0];
    w_src1 = w_wb && r_e_dst == i_addr1 ? w_alu[DATA_W-1:0] :
             o_write_ack && i_addr_write == i_addr1 ? i_data : r_rf[i_addr1];
  end
  // register file: single write port, writeback wins over external write
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (w_wb) begin
      r_rf[r_e_dst] <= w_alu[DATA_W-1:0];
    end else if (o_write_ack) begin
      r_rf[i_addr_write] <= i_data;
    end
  end
  // stage E: latch accepted operation
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_e_valid <= 1'b0;
      r_e_a     <= '0;
      r_e_b     <= '0;
      r_e_sel   <= '0;
      r_e_dst   <= '0;
      r_e_wb    <= 1'b0;
    end else begin
      r_e_valid <= w_accept;
      if (w_accept) begin
        r_e_a   <= w_src0;
        r_e_b   <= w_src1;
        r_e_sel <= i_select;
        r_e_dst <= i_addr_dst;
        r_e_wb  <= i_wb_enable;
      end
    end
  end
  // output stage: register result and flags, pulse valid per completed op
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_result       <= '0;
      o_zero_flag    <= 1'b0;
      o_carry_flag   <= 1'b0;
      o_result_valid <= 1'b0;
    end else begin
      o_result_valid <= r_e_valid;
      if (r_e_valid) begin
        o_result     <= w_alu[DATA_W-1:0];
        o_zero_flag  <= w_alu[DATA_W-1:0] == '0;
        o_carry_flag <= r_e_sel == 3'b000 || r_e_sel == 3'b001 ||
                        r_e_sel == 3'b101 || r_e_sel == 3'b110 ? w_alu[DATA_W] : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb_alu_regfile_pipe: directed checks of ALU ops, forwarding, port arbitration and reset
module tb_alu_regfile_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       we = 1'b0;
  logic [3:0] aw = '0;
  logic       ack;
  logic       ov = 1'b0;
  logic       ordy;
  logic [3:0] a0 = '0;
  logic [3:0] a1 = '0;
  logic [3:0] dst = '0;
  logic       wb = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] res;
  logic       zf;
  logic       cf;
  logic       rv;
  int         n_chk = 0;
  int         n_err = 0;
  alu_regfile_pipe dut (
    .i_clock(clk), .i_reset(rst), .i_data(data), .i_write_enable(we),
    .i_addr_write(aw), .o_write_ack(ack), .i_op_valid(ov), .o_op_ready(ordy),
    .i_addr0(a0), .i_addr1(a1), .i_addr_dst(dst), .i_wb_enable(wb),
    .i_select(sel), .o_result(res), .o_zero_flag(zf), .o_carry_flag(cf),
    .o_result_valid(rv)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; aw = a; data = d;
    step();
    we = 1'b0;
  endtask
  task automatic op(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y,
                    input logic [3:0] d, input logic w);
    ov = 1'b1; sel = s; a0 = x; a1 = y; dst = d; wb = w;
    step();
    ov = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    op(3'b111, a, 4'd0, 4'd0, 1'b0);
    step();
    chk(tag, res, exp);
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    we = 1'b1; aw = 4'd1; data = 8'hAA;
    step(); step();
    chk("rst_ready", ordy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_result", res, 0);
    chk("rst_valid", rv, 0);
    chk("rst_flags", {zf, cf}, 0);
    we = 1'b0; rst = 1'b0;
    #1;
    chk("ready", ordy, 1);
    wr(1, 8'h7F); wr(2, 8'h01);
    op(3'b000, 1, 2, 3, 1'b1);
    step();
    chk("add_res", res, 8'h80);
    chk("add_flags", {zf, cf}, 2'b00);
    chk("add_valid", rv, 1);
    step();
    chk("valid_pulse", rv, 0);
    rd("rd_r3", 3, 8'h80);
    wr(1, 8'hFF);
    op(3'b000, 1, 2, 7, 1'b1);
    step();
    chk("addc_res", res, 8'h00);
    chk("addc_flags", {zf, cf}, 2'b11);
    op(3'b001, 2, 1, 8, 1'b0);
    step();
    chk("sub_res", res, 8'h02);
    chk("sub_flags", {zf, cf}, 2'b01);
    step();
    chk("hold_res", res, 8'h02);
    chk("hold_valid", rv, 0);
    rd("rd_r8_nowb", 8, 8'h00);
    wr(1, 8'd3); wr(2, 8'd4);
    op(3'b000, 1, 2, 4, 1'b1);
    op(3'b000, 4, 4, 5, 1'b1);
    chk("b2b_a", res, 8'd7);
    step();
    chk("b2b_b", res, 8'd14);
    rd("rd_r5", 5, 8'd14);
    ov = 1'b1; sel = 3'b000; a0 = 1; a1 = 2; dst = 4; wb = 1'b1;
    step();
    ov = 1'b0; we = 1'b1; aw = 6; data = 8'h55;
    #1;
    chk("ack_denied", ack, 0);
    step();
    we = 1'b0;
    rd("rd_r6_dropped", 6, 8'h00);
    we = 1'b1;
    #1;
    chk("ack_retry", ack, 1);
    step();
    we = 1'b0;
    rd("rd_r6_retry", 6, 8'h55);
    we = 1'b1; aw = 9; data = 8'h33;
    #1;
    chk("ack_fwd", ack, 1);
    op(3'b111, 9, 0, 0, 1'b0);
    we = 1'b0;
    step();
    chk("wr_fwd", res, 8'h33);
    wr(10, 8'h81);
    op(3'b101, 10, 0, 0, 1'b0);
    step();
    chk("shl", {cf, res}, 9'h102);
    op(3'b110, 10, 0, 0, 1'b0);
    step();
    chk("shr", {cf, res}, 9'h140);
    op(3'b111, 11, 0, 0, 1'b0);
    step();
    chk("pass0", {zf, cf}, 2'b10);
    op(3'b100, 10, 2, 0, 1'b0);
    step();
    chk("xor", {zf, cf, res}, 10'h085);
    op(3'b011, 10, 2, 0, 1'b0);
    step();
    chk("or", res, 8'h85);
    op(3'b010, 10, 2, 0, 1'b0);
    step();
    chk("and", {zf, cf, res}, 10'h200);
    op(3'b000, 1, 2, 12, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_discard", rv, 0);
    rst = 1'b0;
    step();
    chk("rst_no_pulse", rv, 0);
    rd("rd_r12_rst", 12, 8'h00);
    rd("rd_r1_rst", 1, 8'h00);
    chk("rd_r1_zero", zf, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
